// File: rtl/obi_spi_tx_fifo_if.sv
// obi_spi_tx_fifo_if: OBI bus bundle between a bus master and the SPI TX FIFO slave
// Signals keep the slave-side names: request path (req_i, we_i, be_i, addr_i, wdata_i, aid_i)
// and response path (gnt_o, rvalid_o, rdata_o, rid_o, err_o).
interface obi_spi_tx_fifo_if #(
    parameter int ID_WIDTH = 4
);
    logic                req_i;
    logic                we_i;
    logic [3:0]          be_i;
    logic [31:0]         addr_i;
    logic [31:0]         wdata_i;
    logic [ID_WIDTH-1:0] aid_i;
    logic                gnt_o;
    logic                rvalid_o;
    logic [31:0]         rdata_o;
    logic [ID_WIDTH-1:0] rid_o;
    logic                err_o;
    modport master (output req_i, we_i, be_i, addr_i, wdata_i, aid_i,
                    input  gnt_o, rvalid_o, rdata_o, rid_o, err_o);
    modport slave  (input  req_i, we_i, be_i, addr_i, wdata_i, aid_i,
                    output gnt_o, rvalid_o, rdata_o, rid_o, err_o);
endinterface

// File: rtl/obi_spi_tx_fifo.sv
// obi_spi_tx_fifo: OBI byte queue with CS/DC sequencing in front of an SPI shift engine
// Ports: clk_i clock; rst_ni synchronous active-low reset; obi OBI slave (CTRL 0x0, STATUS 0x4,
// TX_CMD 0x8, TX_DAT 0xC); tx_valid_o/tx_data_o/tx_ready_i/tx_done_i shifter handshake;
// cs_no chip select (active low); dc_o command/data line; irq_o transfer-complete interrupt.
// Optional macro OBI_SPI_TX_FIFO_IRQ_EN builds CTRL.IRQ_EN and irq_o; otherwise irq_o is tied 0.
module obi_spi_tx_fifo #(
    parameter int ID_WIDTH_OBI    = 4,
    parameter int DEPTH           = 16,
    parameter int CS_SETUP_CYCLES = 2,
    parameter int CS_HOLD_CYCLES  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    obi_spi_tx_fifo_if.slave        obi,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
    input  logic                    tx_ready_i,
    input  logic                    tx_done_i,
    output logic                    cs_no,
    output logic                    dc_o,
    output logic                    irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_PRESENT = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    logic [8:0]              r_mem [DEPTH];
    logic [AW-1:0]           r_wp, r_rp;
    logic [AW:0]             r_level;
    logic [2:0]              r_state;
    logic [7:0]              r_cnt, r_data;
    logic                    r_enable, r_cs, r_dc;
    logic                    r_rvalid, r_err;
    logic [31:0]             r_rdata;
    logic [ID_WIDTH_OBI-1:0] r_rid;
    logic                    w_empty, w_full, w_wr, w_rd, w_ctrl, w_stat, w_cmd, w_dat, w_mapped;
    logic                    w_ctrl_wr, w_flush, w_push, w_pop, w_go, w_err, w_irq_en, w_unused;
    logic [31:0]             w_rdata;

    assign w_empty   = r_level == '0;
    assign w_full    = r_level == (AW+1)'(DEPTH);
    assign w_wr      = obi.req_i & obi.we_i;
    assign w_rd      = obi.req_i & ~obi.we_i;
    assign w_ctrl    = obi.addr_i[11:0] == 12'h000;
    assign w_stat    = obi.addr_i[11:0] == 12'h004;
    assign w_cmd     = obi.addr_i[11:0] == 12'h008;
    assign w_dat     = obi.addr_i[11:0] == 12'h00C;
    assign w_mapped  = w_ctrl | w_stat | w_cmd | w_dat;
    assign w_ctrl_wr = w_wr & w_ctrl & obi.be_i[0];
    assign w_flush   = w_ctrl_wr & obi.wdata_i[1];
    // Flush in the same cycle blocks the pop so the level cannot underflow.
    assign w_pop     = (r_state == S_PRESENT) & tx_ready_i & ~w_flush;
    // A pop in the same cycle frees a slot, so a push to a full FIFO still lands.
    assign w_push    = w_wr & (w_cmd | w_dat) & (~w_full | w_pop);
    // Ignoring a flushing cycle keeps the FSM from loading a head entry that is being discarded.
    assign w_go      = r_enable & ~w_empty & ~w_flush;
    assign w_err     = ~w_mapped | (w_wr & w_stat) | (w_wr & (w_cmd | w_dat) & ~w_push);
    assign w_rdata   = ~w_rd  ? 32'h0 :
                       w_ctrl ? {27'h0, w_irq_en, 3'h0, r_enable} :
                       w_stat ? {16'h0, 8'(r_level), 5'h0, r_state != S_IDLE, w_full, w_empty} : 32'h0;
    assign w_unused  = ^{obi.addr_i[31:12], obi.be_i[3:1], obi.wdata_i[31:8]};

    assign obi.gnt_o    = obi.req_i;
    assign obi.rvalid_o = r_rvalid;
    assign obi.rdata_o  = r_rdata;
    assign obi.rid_o    = r_rid;
    assign obi.err_o    = r_err;
    assign tx_valid_o   = r_state == S_PRESENT;
    assign tx_data_o    = r_data;
    assign cs_no        = r_cs;
    assign dc_o         = r_dc;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
            r_enable <= 1'b0;
        end else begin
            r_rvalid <= obi.req_i;
            if (obi.req_i) begin
                r_rid   <= obi.aid_i;
                r_err   <= w_err;
                r_rdata <= w_rdata;
            end
            if (w_ctrl_wr) r_enable <= obi.wdata_i[0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= {w_dat, obi.wdata_i[7:0]};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || w_flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cs    <= 1'b1;
            r_dc    <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_go) begin
                    r_state <= S_SETUP;
                    r_cs    <= 1'b0;
                    r_cnt   <= 8'(CS_SETUP_CYCLES - 1);
                end
                // A flush during setup leaves nothing to present, so release CS through hold.
                S_SETUP: if (w_flush || w_empty) begin
                    r_state <= S_HOLD;
                    r_cnt   <= 8'(CS_HOLD_CYCLES - 1);
                end else if (r_cnt == '0) begin
                    r_state         <= S_PRESENT;
                    {r_dc, r_data}  <= r_mem[r_rp];
                end else r_cnt <= r_cnt - 8'd1;
                S_PRESENT: if (tx_ready_i) r_state <= S_SHIFT;
                else if (w_flush) begin
                    r_state <= S_HOLD;
                    r_cnt   <= 8'(CS_HOLD_CYCLES - 1);
                end
                S_SHIFT: if (tx_done_i) begin
                    if (w_go) begin
                        r_state        <= S_PRESENT;
                        {r_dc, r_data} <= r_mem[r_rp];
                    end else begin
                        r_state <= S_HOLD;
                        r_cnt   <= 8'(CS_HOLD_CYCLES - 1);
                    end
                end
                S_HOLD: if (w_go) begin
                    r_state        <= S_PRESENT;
                    {r_dc, r_data} <= r_mem[r_rp];
                end else if (r_cnt == '0) begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                end else r_cnt <= r_cnt - 8'd1;
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b1;
                end
            endcase
        end
    end

`ifdef OBI_SPI_TX_FIFO_IRQ_EN
    logic r_irq_en, r_irq;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= obi.wdata_i[4];
            r_irq <= r_irq_en & w_empty & (r_state == S_IDLE);
        end
    end
    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq_o    = 1'b0;
`endif
endmodule

// File: tb/tb_obi_spi_tx_fifo.sv
// tb_obi_spi_tx_fifo: directed and randomized checks of obi_spi_tx_fifo against a queue model
module tb_obi_spi_tx_fifo;
    localparam int IDW = 4;
`ifdef OBI_SPI_TX_FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       tx_valid_o, tx_ready_i, tx_done_i, cs_no, dc_o, irq_o;
    logic [7:0] tx_data_o;
    logic       man_ready, man_done, sh_ready, sh_done;
    bit         shifter_on;
    int         n_chk, n_pass, n_fail;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [31:0] rd;
    logic        er;

    always #5 clk_i = ~clk_i;

    obi_spi_tx_fifo_if #(.ID_WIDTH(IDW)) obi ();

    assign tx_ready_i = shifter_on ? sh_ready : man_ready;
    assign tx_done_i  = shifter_on ? sh_done : man_done;

    obi_spi_tx_fifo #(.ID_WIDTH_OBI(IDW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .obi(obi),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_ready_i(tx_ready_i),
        .tx_done_i(tx_done_i), .cs_no(cs_no), .dc_o(dc_o), .irq_o(irq_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic obi_op(input logic we, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err);
        logic [IDW-1:0] id;
        id = IDW'($urandom);
        @(negedge clk_i);
        obi.req_i = 1'b1; obi.we_i = we; obi.addr_i = {20'($urandom), a};
        obi.be_i = be; obi.wdata_i = wd; obi.aid_i = id;
        chk("gnt", obi.gnt_o, 1);
        @(negedge clk_i);
        obi.req_i = 1'b0; obi.we_i = 1'b0;
        chk("rvalid", obi.rvalid_o, 1);
        chk("rid", obi.rid_o, id);
        rdata = obi.rdata_o;
        err = obi.err_o;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic exp_err, input string tag);
        logic [31:0] r;
        logic e;
        obi_op(1'b1, a, d, be, r, e);
        chk(tag, e, exp_err);
    endtask

    task automatic rd_chk(input logic [11:0] a, input logic [31:0] exp, input logic exp_err,
                          input string tag);
        logic [31:0] r;
        logic e;
        obi_op(1'b0, a, $urandom, 4'hF, r, e);
        chk(tag, r, exp);
        chk({tag, "_err"}, e, exp_err);
    endtask

    task automatic push(input logic d, input logic [7:0] b, input logic exp_err, input string tag);
        wr(d ? 12'h00C : 12'h008, {24'($urandom), b}, 4'hF, exp_err, tag);
    endtask

    // Wait (bounded) until the run is idle and the expected count of bytes has been shifted,
    // then compare the shifted stream against the model queue.
    task automatic drain_and_compare(input string tag);
        for (int i = 0; i < 3000 && (got_q.size() < exp_q.size() || cs_no !== 1'b1); i++)
            @(negedge clk_i);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk({tag, "_byte"}, i < got_q.size() ? 32'(got_q[i]) : 32'hFFFF_FFFF, 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    // Behavioural shifter: accepts each presented byte after a random delay and reports done later.
    initial begin
        sh_ready = 1'b0;
        sh_done = 1'b0;
        forever begin
            @(negedge clk_i);
            if (shifter_on && tx_valid_o) begin
                got_q.push_back({dc_o, tx_data_o});
                chk("cs_low_while_valid", cs_no, 0);
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                sh_ready = 1'b1;
                @(negedge clk_i);
                sh_ready = 1'b0;
                chk("valid_drop_after_ack", tx_valid_o, 0);
                repeat ($urandom_range(1, 6)) @(negedge clk_i);
                sh_done = 1'b1;
                @(negedge clk_i);
                sh_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic       d;
        n_chk = 0; n_pass = 0; n_fail = 0;
        obi.req_i = 0; obi.we_i = 0; obi.be_i = 0; obi.addr_i = 0; obi.wdata_i = 0; obi.aid_i = 0;
        man_ready = 0; man_done = 0; shifter_on = 0;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_cs", cs_no, 1);
        chk("rst_valid", tx_valid_o, 0);
        chk("rst_data", tx_data_o, 0);
        chk("rst_dc", dc_o, 0);
        chk("rst_irq", irq_o, 0);
        chk("rst_rvalid", obi.rvalid_o, 0);
        chk("rst_rdata", obi.rdata_o, 0);
        chk("rst_err", obi.err_o, 0);
        chk("rst_rid", obi.rid_o, 0);
        chk("rst_gnt", obi.gnt_o, 0);
        rst_ni = 1'b1;
        rd_chk(12'h004, 32'h1, 0, "status_reset");
        rd_chk(12'h000, 32'h0, 0, "ctrl_reset");
        wr(12'h000, 32'h13, 4'b1110, 0, "ctrl_be0_off");
        rd_chk(12'h000, 32'h0, 0, "ctrl_be0_ignored");

        // Two-byte transfer with exact CS/valid timing.
        push(0, 8'h2A, 0, "push_cmd");
        push(1, 8'h55, 0, "push_dat");
        wr(12'h000, 32'h1, 4'hF, 0, "ctrl_en");
        for (int i = 0; i < 20 && cs_no !== 1'b0; i++) @(negedge clk_i);
        chk("cs_fall", cs_no, 0);
        chk("setup_valid0", tx_valid_o, 0);
        @(negedge clk_i);
        chk("setup_valid1", tx_valid_o, 0);
        @(negedge clk_i);
        chk("b0_valid", tx_valid_o, 1);
        chk("b0_data", tx_data_o, 8'h2A);
        chk("b0_dc", dc_o, 0);
        @(negedge clk_i);
        man_ready = 1'b1;
        @(negedge clk_i);
        man_ready = 1'b0;
        chk("b0_shift_valid", tx_valid_o, 0);
        chk("b0_shift_dc", dc_o, 0);
        repeat (7) @(negedge clk_i);
        man_done = 1'b1;
        @(negedge clk_i);
        man_done = 1'b0;
        chk("b1_valid", tx_valid_o, 1);
        chk("b1_data", tx_data_o, 8'h55);
        chk("b1_dc", dc_o, 1);
        chk("cs_between", cs_no, 0);
        @(negedge clk_i);
        man_ready = 1'b1;
        @(negedge clk_i);
        man_ready = 1'b0;
        repeat (7) @(negedge clk_i);
        man_done = 1'b1;
        @(negedge clk_i);
        man_done = 1'b0;
        chk("hold_cs1", cs_no, 0);
        repeat (3) @(negedge clk_i);
        chk("hold_cs4", cs_no, 0);
        @(negedge clk_i);
        chk("cs_rise", cs_no, 1);
        chk("dc_held", dc_o, 1);
        rd_chk(12'h004, 32'h1, 0, "status_after_xfer");

        // Fill to full with random bytes, overflow, then drain and compare.
        wr(12'h000, 32'h0, 4'hF, 0, "ctrl_dis");
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            d = 1'($urandom);
            push(d, b, 0, "push_fill");
            exp_q.push_back({d, b});
        end
        rd_chk(12'h004, 32'h1002, 0, "status_full");
        push(1, 8'hAA, 1, "push_overflow");
        rd_chk(12'h004, 32'h1002, 0, "status_full_again");
        shifter_on = 1'b1;
        wr(12'h000, 32'h1, 4'hF, 0, "ctrl_en_drain");
        drain_and_compare("drain_full");
        rd_chk(12'h004, 32'h1, 0, "status_drained");

        // Streaming pushes with random spacing while the shifter runs.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(3, 14)) @(negedge clk_i);
            b = 8'($urandom);
            d = 1'($urandom);
            push(d, b, 0, "push_stream");
            exp_q.push_back({d, b});
        end
        drain_and_compare("stream");

        // Error responses and read-as-zero registers.
        wr(12'h004, 32'h0, 4'hF, 1, "status_write_err");
        rd_chk(12'h020, 32'h0, 1, "unmapped_read");
        rd_chk(12'h008, 32'h0, 0, "txcmd_read");
        rd_chk(12'h00C, 32'h0, 0, "txdat_read");

        // Flush while a byte is presented.
        shifter_on = 1'b0;
        wr(12'h000, 32'h0, 4'hF, 0, "ctrl_dis2");
        for (int i = 0; i < 3; i++) push(1'($urandom), 8'($urandom), 0, "push_flush");
        rd_chk(12'h004, 32'h0300, 0, "status_level3");
        wr(12'h000, 32'h1, 4'hF, 0, "ctrl_en2");
        for (int i = 0; i < 20 && tx_valid_o !== 1'b1; i++) @(negedge clk_i);
        chk("flush_pre_valid", tx_valid_o, 1);
        wr(12'h000, 32'h3, 4'hF, 0, "ctrl_flush");
        chk("flush_valid_drop", tx_valid_o, 0);
        chk("flush_cs_low", cs_no, 0);
        rd_chk(12'h004, 32'h5, 0, "status_flushed");
        @(negedge clk_i);
        chk("flush_hold_cs", cs_no, 0);
        @(negedge clk_i);
        chk("flush_cs_rise", cs_no, 1);
        rd_chk(12'h000, 32'h1, 0, "ctrl_flush_reads0");

        // Completion interrupt.
        wr(12'h000, 32'h0, 4'hF, 0, "ctrl_dis3");
        b = 8'($urandom);
        push(1, b, 0, "push_irq");
        exp_q.push_back({1'b1, b});
        wr(12'h000, 32'h11, 4'hF, 0, "ctrl_irq_en");
        rd_chk(12'h000, IRQ_ON ? 32'h11 : 32'h01, 0, "ctrl_irq_rb");
        chk("irq_busy", irq_o, 0);
        shifter_on = 1'b1;
        for (int i = 0; i < 20 && cs_no !== 1'b0; i++) @(negedge clk_i);
        chk("irq_cs_fall", cs_no, 0);
        for (int i = 0; i < 100 && cs_no !== 1'b1; i++) @(negedge clk_i);
        chk("irq_idle", cs_no, 1);
        chk("irq_latency", irq_o, 0);
        @(negedge clk_i);
        chk("irq_set", irq_o, 32'(IRQ_ON));
        b = 8'($urandom);
        push(0, b, 0, "push_irq2");
        exp_q.push_back({1'b0, b});
        chk("irq_still", irq_o, 32'(IRQ_ON));
        @(negedge clk_i);
        chk("irq_clear", irq_o, 0);
        drain_and_compare("irq");

        // Reset in the middle of a transfer.
        shifter_on = 1'b0;
        push(0, 8'h3C, 0, "push_rst");
        for (int i = 0; i < 20 && tx_valid_o !== 1'b1; i++) @(negedge clk_i);
        chk("rst_mid_valid", tx_valid_o, 1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_cs", cs_no, 1);
        chk("rst_mid_valid0", tx_valid_o, 0);
        rst_ni = 1'b1;
        rd_chk(12'h004, 32'h1, 0, "status_after_rst");
        rd_chk(12'h000, 32'h0, 0, "ctrl_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/obi_spi_tx_fifo.md
Name: obi_spi_tx_fifo

Overview:
OBI-slave byte queue and chip-select/data-command sequencer that sits directly upstream of the SPI shift engine in the user domain.
- Software pushes command or data bytes; the block tags each byte with a DC bit.
- It presents bytes one at a time to the shifter over a valid/ready/done handshake.
- It drives the external CS and DC lines that the shift engine does not generate.

Parameters:
ID_WIDTH_OBI, SbrObiCfg.IdWidth, OBI ID width
DEPTH, 16, FIFO entries; power of two, at least 2
CS_SETUP_CYCLES, 2, clk cycles from cs_no falling to first tx_valid_o; 1..255
CS_HOLD_CYCLES, 4, clk cycles from last tx_done_i to cs_no rising; 1..255

Ports:
clk_i  in  1  system clock
rst_ni  in  1  synchronous active-low reset
req_i  in  1  OBI request
we_i  in  1  OBI write enable
be_i  in  4  OBI byte enables
addr_i  in  32  OBI address; only [11:0] decoded
wdata_i  in  32  OBI write data
aid_i  in  ID_WIDTH_OBI  OBI request ID
gnt_o  out  1  OBI grant
rvalid_o  out  1  OBI response valid
rdata_o  out  32  OBI read data
rid_o  out  ID_WIDTH_OBI  OBI response ID
err_o  out  1  OBI response error
tx_valid_o  out  1  byte available to the shifter
tx_data_o  out  8  byte to the shifter
tx_ready_i  in  1  shifter accepts the byte
tx_done_i  in  1  one-cycle pulse: shifter finished the byte
cs_no  out  1  chip select, active low
dc_o  out  1  0 = command, 1 = data
irq_o  out  1  transfer-complete interrupt

Behaviour:
Clock and reset:
- One clock, clk_i. Reset rst_ni is synchronous and active-low.
- Outputs after reset: gnt_o follows req_i; rvalid_o=0, err_o=0, rdata_o=0, rid_o=0; tx_valid_o=0, tx_data_o=0; cs_no=1, dc_o=0, irq_o=0.
- After reset: FIFO empty, CTRL=0, FSM in S_IDLE.
- Reset mid-transfer aborts immediately: cs_no=1 on the next edge.

OBI:
- gnt_o = req_i.
- The response comes exactly 1 cycle after grant: rvalid_o=1, rid_o = latched aid_i, err_o and rdata_o from the latched address and latched we.

Registers:
- 0x000 CTRL RW, writes honour be_i[0]:
  - bit0 ENABLE
  - bit1 FLUSH: write-1 clears the FIFO; reads back 0
  - bit4 IRQ_EN
  - other bits read 0
- 0x004 STATUS RO:
  - bit0 EMPTY, bit1 FULL, bit2 BUSY (FSM != S_IDLE)
  - [15:8] LEVEL
  - a write returns err_o=1
- 0x008 TX_CMD WO: pushes wdata_i[7:0] with DC=0.
- 0x00C TX_DAT WO: pushes wdata_i[7:0] with DC=1.
- Reads of 0x008/0x00C return 0 with no error.
- A push to a full FIFO is dropped and returns err_o=1.
- Any unmapped offset returns err_o=1 and rdata_o=0.

FIFO:
- Entries are 9 bits: {dc, byte}. LEVEL is $clog2(DEPTH)+1 bits wide; pointers wrap modulo DEPTH.
- Push and pop in the same cycle: both take effect and LEVEL is unchanged. This is legal even when the FIFO is full.
- FLUSH write: LEVEL=0 on the next edge. FLUSH wins over a simultaneous pop.

FSM:
- S_IDLE: cs_no=1. If ENABLE and not EMPTY, go to S_SETUP (cs_no=0, counter loaded).
- S_SETUP: count CS_SETUP_CYCLES, then go to S_PRESENT. On entry to S_PRESENT, dc_o and tx_data_o load the head entry.
- S_PRESENT: tx_valid_o=1.
  - If tx_ready_i: pop, go to S_SHIFT.
  - If FLUSH: go to S_HOLD with tx_valid_o=0 on the next cycle.
- S_SHIFT: tx_valid_o=0; dc_o is held. On tx_done_i:
  - ENABLE and not EMPTY: go to S_PRESENT.
  - Otherwise: go to S_HOLD.
- S_HOLD: count CS_HOLD_CYCLES.
  - If ENABLE and not EMPTY before expiry: go to S_PRESENT; CS stays low.
  - On expiry: cs_no=1, go to S_IDLE.
- Clearing ENABLE never cuts a byte in S_SHIFT. No new pops occur; the FSM exits through S_HOLD.
- dc_o changes only on entry to S_PRESENT.

IRQ:
- irq_o = IRQ_EN & EMPTY & (state == S_IDLE), registered (1-cycle latency).

Optional Feature:
OBI_SPI_TX_FIFO_IRQ_EN
- Defined: CTRL bit4 IRQ_EN and irq_o behave as above.
- Undefined: CTRL bit4 reads 0 and ignores writes; irq_o is tied 0; no IRQ logic is synthesised.

Test Plan:
1. Reset. Read 0x004 -> rdata 0x0000_0001; cs_no=1, tx_valid_o=0, irq_o=0.
2. CTRL=0x01; write 0x2A to 0x008, then 0x55 to 0x00C; shifter acks next cycle and pulses done 8 cycles later.
   - cs_no falls; tx_valid_o rises 2 cycles later with data 0x2A, dc_o=0.
   - Then data 0x55 with dc_o=1; CS stays low between bytes.
   - cs_no rises 4 cycles after the second tx_done_i.
3. CTRL=0; push 16 bytes -> STATUS 0x0000_1002. 17th push -> err_o=1 and STATUS unchanged.
4. Write to 0x004 -> err_o=1. Read 0x020 -> err_o=1, rdata 0. Read 0x008 -> err_o=0, rdata 0. rid_o equals aid_i in all cases.
5. 3 bytes queued, tx_ready_i held 0; write CTRL=0x03 during S_PRESENT.
   - tx_valid_o=0 next cycle; LEVEL=0.
   - cs_no=1 after 4 cycles.
6. With OBI_SPI_TX_FIFO_IRQ_EN defined: CTRL=0x11, one byte sent -> irq_o=1 one cycle after S_IDLE is reached. A new push drops irq_o next cycle.
